pooled_spike_encoder: RTL and testbench
=======================================

# pooled_spike_encoder

Downstream consumer of the 26x8 block-pooling stage. It captures one pooled frame of 8-bit intensities and converts it into rate-coded spikes. Encoding is integrate-and-fire over `NUM_STEPS` timesteps. Spikes go out as address-events (pixel index plus timestep) on a valid/ready channel toward the neuron array.

## Interface
- `NUM_PIXELS`, default 208: pooled pixels per frame (26 cols x 8 rows, raster order).
- `NUM_STEPS`, default 16: encoding timesteps per frame.
- `ADDR_W`, default 8: width of the spike address, equal to `$clog2(NUM_PIXELS)`.
- `STEP_W`, default 4: width of the spike timestep, equal to `$clog2(NUM_STEPS)`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pixel_in`  in  8: pooled pixel from the pooling stage.
- `valid_in`  in  1: `pixel_in` is valid this cycle.
- `new_frame`  in  1: frame restart, the same strobe that drives the pooling stage.
- `in_ready`  out  1: high while capturing; informational only, because upstream cannot stall.
- `drop_pulse`  out  1: one-cycle pulse when a `valid_in` pixel is discarded.
- `spike_valid`  out  1: an address-event is presented.
- `spike_ready`  in  1: downstream accepts the event.
- `spike_addr`  out  `ADDR_W`: pixel index of the event, 0..`NUM_PIXELS`-1.
- `spike_step`  out  `STEP_W`: timestep of the event.
- `frame_done`  out  1: one-cycle pulse when the frame has been fully encoded.

## Operation
Storage:
- `pix_mem`: `NUM_PIXELS` x 8 bits.
- `acc_mem`: `NUM_PIXELS` x 9 bits.
- Counters: `wr_idx`, `ev_idx` (pixel), `ev_step` (timestep).

The FSM has three states: CAPTURE, ENCODE and FLUSH.

CAPTURE (reset state):
- `in_ready` = 1.
- On `valid_in`: write `pix_mem[wr_idx]` = `pixel_in`, clear `acc_mem[wr_idx]`, then increment `wr_idx`.
- When the write at `wr_idx` = `NUM_PIXELS`-1 completes: go to ENCODE with `ev_idx` = 0 and `ev_step` = 0.

ENCODE:
- `in_ready` = 0.
- Each advancing cycle evaluates pixel `ev_idx` at step `ev_step`:
  - `sum` = `acc_mem[ev_idx]` + `pix_mem[ev_idx]`, computed at 9 bits; the maximum is 510, so it cannot overflow.
  - If `sum` >= 256: the pixel fires; store `sum`-256 and register an event with `spike_addr` = `ev_idx` and `spike_step` = `ev_step`.
  - Otherwise: store `sum`; no event.
- Advance order: increment `ev_idx`. When it wraps from `NUM_PIXELS`-1 to 0, increment `ev_step`.
- A cycle advances unless `spike_valid` && !`spike_ready`.
- After evaluating (`NUM_PIXELS`-1, `NUM_STEPS`-1):
  - if an event is pending or just registered, go to FLUSH;
  - otherwise pulse `frame_done` and go to CAPTURE with `wr_idx` = 0.

FLUSH:
- Hold the final event until it is accepted.
- On acceptance: pulse `frame_done` on the next cycle and return to CAPTURE with `wr_idx` = 0.

Spike count per pixel value p over the frame is floor(p·`NUM_STEPS`/256). The first spike falls on step ceil(256/p)-1.

Boundary rules:
- `valid_in` outside CAPTURE: the pixel is discarded and `drop_pulse` = 1 for that cycle.
- `new_frame` in any state:
  - highest priority;
  - on the next edge: state = CAPTURE, `wr_idx` = 0, `spike_valid` = 0, `frame_done` = 0;
  - any pending event is abandoned;
  - a pixel presented in the same cycle is discarded, with no `drop_pulse`.
- `rst_n` low mid-operation: all state clears immediately. Memories need no reset, because CAPTURE rewrites every entry before use.

## Timing
Reset values:
- `spike_valid` 0, `spike_addr` 0, `spike_step` 0.
- `frame_done` 0, `drop_pulse` 0.
- `in_ready` 1 (state CAPTURE).

Latencies:
- Capture: ENCODE is entered on the edge that writes pixel `NUM_PIXELS`-1, so ENCODE is active on the following cycle.
- Event: `spike_valid` rises on the edge after the evaluating cycle. `spike_addr` and `spike_step` stay stable while `spike_valid` && !`spike_ready`.
- Transfer occurs on the edge where `spike_valid` && `spike_ready`. If the current evaluation fires, the next event is presented on the same edge; back-to-back events are possible at full throughput.
- With no backpressure, ENCODE lasts exactly `NUM_PIXELS`·`NUM_STEPS` = 3328 cycles, and `frame_done` follows the last evaluation by 1 cycle (FLUSH occupies that cycle only when an event is pending).
- Each stall cycle extends encoding by exactly one cycle.

## Test plan
- All 208 pixels = 0, `spike_ready` = 1 → no events; `frame_done` pulses exactly once, 3329 cycles after the last capture edge.
- All pixels = 255 → 15 events per address, 3120 total; the first event is (addr 0, step 1); no event carries step 0.
- Pixel 5 = 128, all others 0 → 8 events, all addr 5, steps 1, 3, 5, …, 15.
- Pixel 0 = 255, others 0, `spike_ready` held low 10 cycles at the first event → addr 0 / step 1 holds steady for 10 cycles; total encode time 3338 cycles; event count unchanged.
- 5 `valid_in` pulses during ENCODE → 5 `drop_pulse`s; encoded output is identical to the frame with no extra pixels.
- `new_frame` mid-ENCODE with an event pending → `spike_valid` = 0 next cycle and `in_ready` = 1; a following full frame of pixel value 64 yields exactly 4 events per address at steps 3, 7, 11, 15 (832 events total).

Source files
------------

// File: rtl/pooled_spike_encoder.sv
// Captures one pooled frame of 8-bit intensities and rate-codes it into
// address-events with an integrate-and-fire encoder over NUM_STEPS timesteps.
module pooled_spike_encoder #(
  parameter int NUM_PIXELS = 208,
  parameter int NUM_STEPS  = 16,
  parameter int ADDR_W     = 8,
  parameter int STEP_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pixel_in,
  input  logic              valid_in,
  input  logic              new_frame,
  output logic              in_ready,
  output logic              drop_pulse,
  output logic              spike_valid,
  input  logic              spike_ready,
  output logic [ADDR_W-1:0] spike_addr,
  output logic [STEP_W-1:0] spike_step,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_ENCODE  = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  logic [7:0] pix_mem [NUM_PIXELS];
  logic [8:0] acc_mem [NUM_PIXELS];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0]   ev_idx_q, ev_idx_d;
  logic [STEP_W-1:0]   ev_step_q, ev_step_d;
  logic                spike_valid_q, spike_valid_d;
  logic [ADDR_W-1:0]   spike_addr_q, spike_addr_d;
  logic [STEP_W-1:0]   spike_step_q, spike_step_d;
  logic                frame_done_q, frame_done_d;
  logic                drop_pulse_q, drop_pulse_d;
  logic                in_ready_q, in_ready_d;

  logic                cap_wr_s;
  logic                advance_s;
  logic                xfer_s;
  logic                fire_s;
  logic [7:0]          pix_rd_s;
  logic [8:0]          acc_rd_s;
  logic [8:0]          sum_s;
  logic [8:0]          acc_wr_s;

  // An evaluation only stalls when an unaccepted event would be overwritten.
  assign cap_wr_s  = (state_q == ST_CAPTURE) && valid_in && !new_frame;
  assign xfer_s    = spike_valid_q && spike_ready;
  assign advance_s = (state_q == ST_ENCODE) && !new_frame && !(spike_valid_q && !spike_ready);

  assign pix_rd_s  = pix_mem[ev_idx_q];
  assign acc_rd_s  = acc_mem[ev_idx_q];
  assign sum_s     = acc_rd_s + {1'b0, pix_rd_s};
  assign fire_s    = sum_s[8];
  assign acc_wr_s  = fire_s ? {1'b0, sum_s[7:0]} : sum_s;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    ev_idx_d      = ev_idx_q;
    ev_step_d     = ev_step_q;
    spike_valid_d = spike_valid_q;
    spike_addr_d  = spike_addr_q;
    spike_step_d  = spike_step_q;
    frame_done_d  = 1'b0;
    drop_pulse_d  = valid_in && !new_frame && (state_q != ST_CAPTURE);

    if (new_frame) begin
      state_d       = ST_CAPTURE;
      wr_idx_d      = '0;
      ev_idx_d      = '0;
      ev_step_d     = '0;
      spike_valid_d = 1'b0;
    end else begin
      if (xfer_s) begin
        spike_valid_d = 1'b0;
      end else begin
        spike_valid_d = spike_valid_q;
      end

      case (state_q)
        ST_CAPTURE: begin
          if (valid_in) begin
            wr_idx_d = wr_idx_q + ADDR_W'(1);
            if (wr_idx_q == LAST_PIX) begin
              state_d   = ST_ENCODE;
              ev_idx_d  = '0;
              ev_step_d = '0;
            end else begin
              state_d = ST_CAPTURE;
            end
          end else begin
            wr_idx_d = wr_idx_q;
          end
        end

        ST_ENCODE: begin
          if (advance_s) begin
            if (fire_s) begin
              spike_valid_d = 1'b1;
              spike_addr_d  = ev_idx_q;
              spike_step_d  = ev_step_q;
            end else begin
              spike_addr_d  = spike_addr_q;
            end

            if (ev_idx_q == LAST_PIX) begin
              ev_idx_d  = '0;
              ev_step_d = ev_step_q + STEP_W'(1);
            end else begin
              ev_idx_d  = ev_idx_q + ADDR_W'(1);
            end

            // The final evaluation either leaves an event to drain or ends the frame.
            if ((ev_idx_q == LAST_PIX) && (ev_step_q == LAST_STEP)) begin
              if (fire_s) begin
                state_d = ST_FLUSH;
              end else begin
                state_d      = ST_CAPTURE;
                wr_idx_d     = '0;
                frame_done_d = 1'b1;
              end
            end else begin
              state_d = ST_ENCODE;
            end
          end else begin
            state_d = ST_ENCODE;
          end
        end

        ST_FLUSH: begin
          if (xfer_s) begin
            state_d      = ST_CAPTURE;
            wr_idx_d     = '0;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_FLUSH;
          end
        end

        default: begin
          state_d  = ST_CAPTURE;
          wr_idx_d = '0;
        end
      endcase
    end

    in_ready_d = (state_d == ST_CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_CAPTURE;
      wr_idx_q      <= '0;
      ev_idx_q      <= '0;
      ev_step_q     <= '0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      spike_step_q  <= '0;
      frame_done_q  <= 1'b0;
      drop_pulse_q  <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      ev_idx_q      <= ev_idx_d;
      ev_step_q     <= ev_step_d;
      spike_valid_q <= spike_valid_d;
      spike_addr_q  <= spike_addr_d;
      spike_step_q  <= spike_step_d;
      frame_done_q  <= frame_done_d;
      drop_pulse_q  <= drop_pulse_d;
      in_ready_q    <= in_ready_d;
    end
  end

  // Memories are fully rewritten during capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (cap_wr_s) begin
      pix_mem[wr_idx_q] <= pixel_in;
      acc_mem[wr_idx_q] <= 9'd0;
    end else if (advance_s) begin
      acc_mem[ev_idx_q] <= acc_wr_s;
    end
  end

  assign in_ready    = in_ready_q;
  assign drop_pulse  = drop_pulse_q;
  assign spike_valid = spike_valid_q;
  assign spike_addr  = spike_addr_q;
  assign spike_step  = spike_step_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_pooled_spike_encoder.sv
// Self-checking bench for pooled_spike_encoder: directed and random frames
// compared against a closed-form rate-coding model.
module tb_pooled_spike_encoder;

  localparam int NP    = 208;
  localparam int NS    = 16;
  localparam int AW    = 8;
  localparam int SW    = 4;
  localparam int LIMIT = 20000;

  logic          clk;
  logic          rst_n;
  logic [7:0]    pixel_in;
  logic          valid_in;
  logic          new_frame;
  logic          in_ready;
  logic          drop_pulse;
  logic          spike_valid;
  logic          spike_ready;
  logic [AW-1:0] spike_addr;
  logic [SW-1:0] spike_step;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_pix [NP];
  logic [11:0] exp_q [$];
  logic [11:0] got_q [$];
  int fd_total    = 0;
  int drop_total  = 0;
  int busy_total  = 0;
  int stall_total = 0;

  pooled_spike_encoder #(.NUM_PIXELS(NP), .NUM_STEPS(NS), .ADDR_W(AW), .STEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .new_frame(new_frame), .in_ready(in_ready), .drop_pulse(drop_pulse),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_addr(spike_addr),
    .spike_step(spike_step), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: records transfers and per-cycle status away from the clock edge.
  always @(negedge clk) begin
    #1;
    if (spike_valid && spike_ready) got_q.push_back({spike_addr, spike_step});
    if (frame_done) fd_total++;
    if (drop_pulse) drop_total++;
    if (!in_ready) busy_total++;
    if (!in_ready && spike_valid && !spike_ready) stall_total++;
  end

  // Pixel p fires at step s exactly when floor(p*(s+1)/256) exceeds floor(p*s/256).
  function automatic void build_expected();
    exp_q.delete();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < NP; i++) begin
        int p;
        p = int'(frame_pix[i]);
        if (((s + 1) * p) / 256 > (s * p) / 256) exp_q.push_back({8'(i), 4'(s)});
      end
  endfunction

  function automatic int first_diff(input int base);
    for (int k = 0; k < exp_q.size(); k++)
      if (got_q[base + k] !== exp_q[k]) return k;
    return -1;
  endfunction

  task automatic send_frame();
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      spike_ready = 1'b1;
      pixel_in    = frame_pix[i];
      valid_in    = 1'b1;
    end
  endtask

  task automatic wait_done(input int drops, input bit rand_ready, output int n);
    int c;
    n = 0;
    do begin
      @(negedge clk);
      c = n + 1;
      valid_in = (drops > 0) && (c % 100 == 0) && (c <= 100 * drops);
      pixel_in = 8'($urandom);
      if (rand_ready) spike_ready = ($urandom_range(0, 9) < 7);
      #2;
      n++;
    end while (!frame_done && n < LIMIT);
    valid_in = 1'b0;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL frame_done_timeout: got no pulse in %0d cycles, expected a pulse", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; new_frame = 1'b0; pixel_in = 8'd0; spike_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (spike_valid !== 1'b0) begin errors++; $display("FAIL reset_spike_valid: got %0b expected 0", spike_valid); end
    checks++; if (spike_addr !== 8'd0) begin errors++; $display("FAIL reset_spike_addr: got %0d expected 0", spike_addr); end
    checks++; if (spike_step !== 4'd0) begin errors++; $display("FAIL reset_spike_step: got %0d expected 0", spike_step); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse: got %0b expected 0", drop_pulse); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_frame();
    int n, base, fd0, busy0;
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'd0;
    base = got_q.size(); fd0 = fd_total; busy0 = busy_total;
    send_frame();
    wait_done(0, 1'b0, n);
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() - base !== 0) begin errors++; $display("FAIL zero_events: got %0d expected 0", got_q.size() - base); end
    checks++; if (n !== 3329) begin errors++; $display("FAIL zero_done_latency: got %0d expected 3329", n); end
    checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", fd_total - fd0); end
    checks++; if (busy_total - busy0 !== 3328) begin errors++; $display("FAIL zero_encode_cycles: got %0d expected 3328", busy_total - busy0); end
  endtask

  task automatic test_back_to_back();
    int n, base, busy0, d, step0;
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'd255;
    build_expected();
    base = got_q.size(); busy0 = busy_total;
    send_frame();
    wait_done(0, 1'b0, n);
    step0 = 0;
    for (int k = base; k < got_q.size(); k++) if (got_q[k][3:0] == 4'd0) step0++;
    checks++; if (got_q.size() - base !== 3120) begin errors++; $display("FAIL max_event_count: got %0d expected 3120", got_q.size() - base); end
    checks++;
    if (got_q.size() <= base) begin errors++; $display("FAIL max_first_event: got none expected addr 0 step 1"); end
    else if (got_q[base] !== {8'd0, 4'd1}) begin errors++; $display("FAIL max_first_event: got %h expected 001", got_q[base]); end
    checks++; if (step0 !== 0) begin errors++; $display("FAIL max_step0_events: got %0d expected 0", step0); end
    checks++; if (busy_total - busy0 !== 3329) begin errors++; $display("FAIL max_busy_cycles: got %0d expected 3329", busy_total - busy0); end
    checks++; if (n !== 3330) begin errors++; $display("FAIL max_done_latency: got %0d expected 3330", n); end
    d = (got_q.size() - base == exp_q.size()) ? first_diff(base) : -2;
    checks++; if (d != -1) begin errors++; $display("FAIL max_event_stream: first difference at %0d, got %0d events expected %0d", d, got_q.size() - base, exp_q.size()); end
  endtask

  task automatic test_single_pixel();
    int n, base;
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'd0;
    frame_pix[5] = 8'd128;
    base = got_q.size();
    send_frame();
    wait_done(0, 1'b0, n);
    checks++; if (got_q.size() - base !== 8) begin errors++; $display("FAIL single_event_count: got %0d expected 8", got_q.size() - base); end
    for (int k = 0; k < 8 && base + k < got_q.size(); k++) begin
      checks++;
      if (got_q[base + k] !== {8'd5, 4'(2 * k + 1)}) begin
        errors++; $display("FAIL single_event_%0d: got %h expected %h", k, got_q[base + k], {8'd5, 4'(2 * k + 1)});
      end
    end
  endtask

  task automatic test_backpressure();
    int n, base, busy0, stall, d;
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'd0;
    frame_pix[0] = 8'd255;
    build_expected();
    base = got_q.size(); busy0 = busy_total;
    send_frame();
    n = 0; stall = 0;
    do begin
      @(negedge clk);
      valid_in = 1'b0;
      spike_ready = (stall >= 10);
      #2;
      n++;
      if (spike_valid && !spike_ready) begin
        checks++;
        if ({spike_addr, spike_step} !== {8'd0, 4'd1}) begin
          errors++; $display("FAIL bp_hold_event: got %h expected 001", {spike_addr, spike_step});
        end
        stall++;
      end
    end while (!frame_done && n < LIMIT);
    checks++; if (stall !== 10) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 10", stall); end
    checks++; if (busy_total - busy0 !== 3338) begin errors++; $display("FAIL bp_encode_cycles: got %0d expected 3338", busy_total - busy0); end
    d = (got_q.size() - base == exp_q.size()) ? first_diff(base) : -2;
    checks++; if (d != -1) begin errors++; $display("FAIL bp_event_stream: diff at %0d, got %0d events expected %0d", d, got_q.size() - base, exp_q.size()); end
  endtask

  task automatic test_drops();
    int n, base, drop0, d;
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'($urandom);
    build_expected();
    base = got_q.size(); drop0 = drop_total;
    send_frame();
    wait_done(5, 1'b0, n);
    checks++; if (drop_total - drop0 !== 5) begin errors++; $display("FAIL drop_pulses: got %0d expected 5", drop_total - drop0); end
    d = (got_q.size() - base == exp_q.size()) ? first_diff(base) : -2;
    checks++; if (d != -1) begin errors++; $display("FAIL drop_event_stream: diff at %0d, got %0d events expected %0d", d, got_q.size() - base, exp_q.size()); end
  endtask

  task automatic test_new_frame();
    int n, base, k, bad, d;
    bit seen;
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'd255;
    send_frame();
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk);
      valid_in = 1'b0; spike_ready = 1'b0;
      #2;
      if (spike_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL nf_pending_event: got none expected a pending event"); end
    @(negedge clk);
    new_frame = 1'b1; valid_in = 1'b1; pixel_in = 8'd77;
    @(negedge clk);
    new_frame = 1'b0; valid_in = 1'b0;
    #2;
    checks++; if (spike_valid !== 1'b0) begin errors++; $display("FAIL nf_spike_valid: got %0b expected 0", spike_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nf_in_ready: got %0b expected 1", in_ready); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL nf_drop_pulse: got %0b expected 0", drop_pulse); end
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'd64;
    build_expected();
    base = got_q.size();
    send_frame();
    wait_done(0, 1'b0, n);
    bad = 0;
    for (k = base; k < got_q.size(); k++)
      if (got_q[k][1:0] != 2'd3) bad++;
    checks++; if (got_q.size() - base !== 832) begin errors++; $display("FAIL nf_64_count: got %0d expected 832", got_q.size() - base); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL nf_64_steps: got %0d events off steps 3/7/11/15 expected 0", bad); end
    d = (got_q.size() - base == exp_q.size()) ? first_diff(base) : -2;
    checks++; if (d != -1) begin errors++; $display("FAIL nf_64_stream: diff at %0d, got %0d events expected %0d", d, got_q.size() - base, exp_q.size()); end
  endtask

  task automatic test_random();
    int n, base, busy0, stall0, fd0, d, expbusy, p;
    for (int i = 0; i < NP; i++) frame_pix[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    build_expected();
    p = int'(frame_pix[NP-1]);
    base = got_q.size(); busy0 = busy_total; stall0 = stall_total; fd0 = fd_total;
    send_frame();
    wait_done(0, 1'b1, n);
    expbusy = 3328 + (stall_total - stall0) + (((16 * p) / 256 > (15 * p) / 256) ? 1 : 0);
    d = (got_q.size() - base == exp_q.size()) ? first_diff(base) : -2;
    checks++; if (d != -1) begin errors++; $display("FAIL rand_event_stream: diff at %0d, got %0d events expected %0d", d, got_q.size() - base, exp_q.size()); end
    checks++; if (busy_total - busy0 !== expbusy) begin errors++; $display("FAIL rand_encode_cycles: got %0d expected %0d", busy_total - busy0, expbusy); end
    checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL rand_done_pulses: got %0d expected 1", fd_total - fd0); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < NP; i++) frame_pix[i] = 8'd255;
    send_frame();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    @(negedge clk);
    #3; rst_n = 1'b0; #1;
    checks++; if (spike_valid !== 1'b0) begin errors++; $display("FAIL arst_spike_valid: got %0b expected 0", spike_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %0b expected 1", in_ready); end
    checks++; if ({spike_addr, spike_step} !== 12'd0) begin errors++; $display("FAIL arst_event_fields: got %h expected 000", {spike_addr, spike_step}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_back_to_back();
    test_single_pixel();
    test_backpressure();
    test_drops();
    test_new_frame();
    test_random();
    test_async_reset();
    test_single_pixel();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
